// File: rtl/vedic_mac_acc_if.sv
// Handshake bus for vedic_mac_acc.
//   master : drives clear, in_valid, a, b, out_ready; observes in_ready, out_valid, result, overflow
//   slave  : the accumulator side (opposite directions)
interface vedic_mac_acc_if #(
    parameter int unsigned ACC_W = 24
) ();
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             overflow;

    modport master (
        output clear, in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  clear, in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/vedic_mac_acc.sv
// Block multiply-accumulate: sums BLOCK_LEN unsigned 8x8 products (Vedic multiplier)
// into a saturating ACC_W-bit accumulator and presents one result per block.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : vedic_mac_acc_if.slave (clear, in_valid/in_ready/a/b, out_valid/out_ready/result/overflow)
// Pipeline: stage P registers the product, stage A accumulates it; the last product of a
// block loads the output register and restarts the accumulator from zero on the same edge.

// 2x2 Vedic (Urdhva Tiryagbhyam) cell.
module vedic_mul2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);
    logic w_t1, w_t2, w_c, w_hh;

    assign w_t1 = i_a[1] & i_b[0];
    assign w_t2 = i_a[0] & i_b[1];
    assign w_c  = w_t1 & w_t2;
    assign w_hh = i_a[1] & i_b[1];
    assign o_p  = {w_hh & w_c, w_hh ^ w_c, w_t1 ^ w_t2, i_a[0] & i_b[0]};
endmodule

// 4x4 Vedic multiplier built from four 2x2 cells.
module vedic_mul4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [3:0] w_ll, w_lh, w_hl, w_hh;

    vedic_mul2 u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_ll));
    vedic_mul2 u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_lh));
    vedic_mul2 u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_hl));
    vedic_mul2 u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_hh));

    assign o_p = 8'(w_ll) + (8'(w_lh) << 2) + (8'(w_hl) << 2) + (8'(w_hh) << 4);
endmodule

// 8x8 Vedic multiplier built from four 4x4 blocks.
module vedic_mul8 (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_p
);
    logic [7:0] w_ll, w_lh, w_hl, w_hh;

    vedic_mul4 u_ll (.i_a(i_a[3:0]), .i_b(i_b[3:0]), .o_p(w_ll));
    vedic_mul4 u_lh (.i_a(i_a[3:0]), .i_b(i_b[7:4]), .o_p(w_lh));
    vedic_mul4 u_hl (.i_a(i_a[7:4]), .i_b(i_b[3:0]), .o_p(w_hl));
    vedic_mul4 u_hh (.i_a(i_a[7:4]), .i_b(i_b[7:4]), .o_p(w_hh));

    assign o_p = 16'(w_ll) + (16'(w_lh) << 4) + (16'(w_hl) << 4) + (16'(w_hh) << 8);
endmodule

module vedic_mac_acc #(
    parameter int unsigned BLOCK_LEN = 8,
    parameter int unsigned ACC_W     = 24
) (
    input logic             clk,
    input logic             rst_n,
    vedic_mac_acc_if.slave  bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    logic [15:0]      w_prod;
    logic [15:0]      r_p;
    logic             r_p_valid;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_result;
    logic             r_overflow;
    logic             r_out_valid;

    logic [SUM_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_next;
    logic             w_stall;
    logic             w_last;
    logic             w_hold;
    logic             w_accum;
    logic             w_load;
    logic             w_in_ready;
    logic             w_xfer;

    vedic_mul8 u_mul (.i_a(bus.a), .i_b(bus.b), .o_p(w_prod));

    // Saturating add and handshake control.
    always_comb begin
        w_sum      = SUM_W'(r_acc) + SUM_W'(r_p);
        w_acc_next = w_sum[ACC_W] ? ACC_MAX : w_sum[ACC_W-1:0];
        w_ovf_next = r_ovf | w_sum[ACC_W];
        w_stall    = r_out_valid && !bus.out_ready;
        w_last     = r_p_valid && (r_cnt == LAST_IDX);
        // A block-completing product waits in stage P rather than overwrite a stalled result;
        // only reachable with BLOCK_LEN=1.
        w_hold     = w_last && w_stall;
        w_accum    = r_p_valid && !w_hold && !bus.clear;
        w_load     = w_accum && (r_cnt == LAST_IDX);
        w_in_ready = rst_n && !w_stall && !bus.clear && !w_hold;
        w_xfer     = bus.in_valid && w_in_ready;
    end

    // Product and accumulator stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else if (bus.clear) begin
            r_p_valid <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_p_valid <= w_xfer || w_hold;
            if (w_xfer) begin
                r_p <= w_prod;
            end
            if (w_load) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_accum) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CNT_W'(1);
                r_ovf <= w_ovf_next;
            end
        end
    end

    // Output register: a new result wins over a same-edge drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_acc_next;
            r_overflow  <= w_ovf_next;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_vedic_mac_acc.sv
// Directed and randomized checks of vedic_mac_acc: an 8-product/24-bit instance and a
// 2-product/16-bit instance for saturation.
module tb_vedic_mac_acc;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vedic_mac_acc_if #(.ACC_W(24)) bus8 ();
    vedic_mac_acc_if #(.ACC_W(16)) bus16 ();

    vedic_mac_acc #(.BLOCK_LEN(8), .ACC_W(24)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    vedic_mac_acc #(.BLOCK_LEN(2), .ACC_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    int n_vec = 0;
    int n_err = 0;
    logic [24:0] q8[$];
    logic [16:0] q16[$];

    // Record every accepted result as {overflow, result}.
    always @(negedge clk) begin
        if (rst_n && bus8.out_valid && bus8.out_ready) q8.push_back({bus8.overflow, bus8.result});
        if (rst_n && bus16.out_valid && bus16.out_ready) q16.push_back({bus16.overflow, bus16.result});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed8(input logic [7:0] a, input logic [7:0] b);
        int w;
        w = 0;
        bus8.a = a;
        bus8.b = b;
        bus8.in_valid = 1'b1;
        #1;
        while (!bus8.in_ready && w < 50) begin
            cyc();
            w++;
        end
        if (w >= 50) begin
            n_vec++; n_err++;
            $display("FAIL feed8_timeout in_ready got 0 want 1");
        end
        cyc();
    endtask

    task automatic feed16(input logic [7:0] a, input logic [7:0] b);
        int w;
        w = 0;
        bus16.a = a;
        bus16.b = b;
        bus16.in_valid = 1'b1;
        #1;
        while (!bus16.in_ready && w < 50) begin
            cyc();
            w++;
        end
        if (w >= 50) begin
            n_vec++; n_err++;
            $display("FAIL feed16_timeout in_ready got 0 want 1");
        end
        cyc();
    endtask

    task automatic wait8(input int n);
        int w;
        w = 0;
        while (q8.size() < n && w < 100) begin
            cyc();
            w++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        n_vec++; if (bus8.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %0b want 0", bus8.in_ready); end
        n_vec++; if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", bus8.out_valid); end
        n_vec++; if (bus8.result !== 24'd0) begin n_err++; $display("FAIL reset_result got %0d want 0", bus8.result); end
        n_vec++; if (bus8.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0b want 0", bus8.overflow); end
        n_vec++; if (bus16.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready16 got %0b want 0", bus16.in_ready); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got %0b want 1", bus8.in_ready); end
        cyc();
    endtask

    task automatic test_full_block();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus8.a = 8'd255;
            bus8.b = 8'd255;
            bus8.in_valid = 1'b1;
            #1;
            n_vec++; if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL full_in_ready[%0d] got %0b want 1", i, bus8.in_ready); end
            cyc();
        end
        bus8.in_valid = 1'b0;
        n_vec++; if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid got %0b want 0", bus8.out_valid); end
        cyc();
        n_vec++; if (bus8.out_valid !== 1'b1) begin n_err++; $display("FAIL full_latency_valid got %0b want 1", bus8.out_valid); end
        n_vec++; if (bus8.result !== 24'd520200) begin n_err++; $display("FAIL full_result got %0d want 520200", bus8.result); end
        n_vec++; if (bus8.overflow !== 1'b0) begin n_err++; $display("FAIL full_overflow got %0b want 0", bus8.overflow); end
        cyc();
        n_vec++; if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL full_one_cycle got %0b want 0", bus8.out_valid); end
        n_vec++; if (q8.size() !== 1) begin n_err++; $display("FAIL full_count got %0d want 1", q8.size()); end
        q8.delete();
    endtask

    task automatic test_saturation();
        logic [16:0] e;
        feed16(8'd255, 8'd255);
        feed16(8'd255, 8'd255);
        feed16(8'd1, 8'd1);
        feed16(8'd2, 8'd3);
        bus16.in_valid = 1'b0;
        for (int w = 0; w < 10; w++) cyc();
        n_vec++; if (q16.size() !== 2) begin n_err++; $display("FAIL sat_count got %0d want 2", q16.size()); end
        if (q16.size() >= 1) begin
            e = q16.pop_front();
            n_vec++; if (e[15:0] !== 16'hFFFF) begin n_err++; $display("FAIL sat_result got %0d want 65535", e[15:0]); end
            n_vec++; if (e[16] !== 1'b1) begin n_err++; $display("FAIL sat_overflow got %0b want 1", e[16]); end
        end
        if (q16.size() >= 1) begin
            e = q16.pop_front();
            n_vec++; if (e[15:0] !== 16'd7) begin n_err++; $display("FAIL sat_next_result got %0d want 7", e[15:0]); end
            n_vec++; if (e[16] !== 1'b0) begin n_err++; $display("FAIL sat_next_overflow got %0b want 0", e[16]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] e;
        logic [24:0] want[2];
        want[0] = {1'b0, 24'd204};
        want[1] = {1'b0, 24'd800};
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus8.a = (i < 8) ? 8'(i + 1) : 8'd10;
            bus8.b = bus8.a;
            bus8.in_valid = 1'b1;
            #1;
            n_vec++; if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d] got %0b want 1", i, bus8.in_ready); end
            cyc();
        end
        bus8.in_valid = 1'b0;
        wait8(2);
        n_vec++; if (q8.size() !== 2) begin n_err++; $display("FAIL b2b_count got %0d want 2", q8.size()); end
        for (int k = 0; k < 2; k++) begin
            if (q8.size() >= 1) begin
                e = q8.pop_front();
                n_vec++; if (e !== want[k]) begin n_err++; $display("FAIL b2b_result[%0d] got %0d/%0b want %0d/%0b", k, e[23:0], e[24], want[k][23:0], want[k][24]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [24:0] e;
        int w;
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed8(8'd3, 8'd5);
        bus8.in_valid = 1'b0;
        w = 0;
        while (!bus8.out_valid && w < 20) begin cyc(); w++; end
        for (int k = 0; k < 5; k++) begin
            bus8.clear = (k == 2);
            bus8.in_valid = 1'b1;
            bus8.a = 8'd9;
            bus8.b = 8'd9;
            #1;
            n_vec++; if (bus8.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %0b want 0", k, bus8.in_ready); end
            n_vec++; if (bus8.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %0b want 1", k, bus8.out_valid); end
            n_vec++; if (bus8.result !== 24'd120) begin n_err++; $display("FAIL stall_result[%0d] got %0d want 120", k, bus8.result); end
            cyc();
        end
        bus8.clear = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) feed8(8'(i + 1), 8'd2);
        bus8.in_valid = 1'b0;
        wait8(2);
        n_vec++; if (q8.size() !== 2) begin n_err++; $display("FAIL stall_count got %0d want 2", q8.size()); end
        if (q8.size() >= 1) begin
            e = q8.pop_front();
            n_vec++; if (e !== {1'b0, 24'd120}) begin n_err++; $display("FAIL stall_first got %0d want 120", e[23:0]); end
        end
        if (q8.size() >= 1) begin
            e = q8.pop_front();
            n_vec++; if (e !== {1'b0, 24'd72}) begin n_err++; $display("FAIL stall_second got %0d want 72", e[23:0]); end
        end
    endtask

    task automatic test_clear();
        logic [24:0] e;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) feed8(8'd200, 8'd200);
        bus8.clear = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.a = 8'd50;
        bus8.b = 8'd50;
        #1;
        n_vec++; if (bus8.in_ready !== 1'b0) begin n_err++; $display("FAIL clear_in_ready got %0b want 0", bus8.in_ready); end
        cyc();
        bus8.clear = 1'b0;
        bus8.in_valid = 1'b0;
        cyc();
        for (int i = 1; i <= 8; i++) feed8(8'(i), 8'(i));
        bus8.in_valid = 1'b0;
        wait8(1);
        for (int w = 0; w < 4; w++) cyc();
        n_vec++; if (q8.size() !== 1) begin n_err++; $display("FAIL clear_count got %0d want 1", q8.size()); end
        if (q8.size() >= 1) begin
            e = q8.pop_front();
            n_vec++; if (e !== {1'b0, 24'd204}) begin n_err++; $display("FAIL clear_result got %0d want 204", e[23:0]); end
        end
        q8.delete();
    endtask

    task automatic test_reset_mid();
        logic [24:0] e;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed8(8'd100, 8'd100);
        bus8.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus8.in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready got %0b want 0", bus8.in_ready); end
        cyc();
        n_vec++; if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b want 0", bus8.out_valid); end
        n_vec++; if (bus8.result !== 24'd0) begin n_err++; $display("FAIL rstmid_result got %0d want 0", bus8.result); end
        n_vec++; if (bus8.overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow got %0b want 0", bus8.overflow); end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) feed8(8'd16, 8'd16);
        bus8.in_valid = 1'b0;
        wait8(1);
        for (int w = 0; w < 4; w++) cyc();
        n_vec++; if (q8.size() !== 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", q8.size()); end
        if (q8.size() >= 1) begin
            e = q8.pop_front();
            n_vec++; if (e !== {1'b0, 24'd2048}) begin n_err++; $display("FAIL rstmid_result_after got %0d want 2048", e[23:0]); end
        end
        q8.delete();
    endtask

    task automatic test_random();
        logic [24:0] eq[$];
        logic [24:0] e;
        longint macc;
        int mcnt;
        int n;
        macc = 0;
        mcnt = 0;
        for (int c = 0; c < 10000; c++) begin
            bus8.in_valid = ($urandom % 4) != 0;
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            bus8.out_ready = ($urandom % 4) != 0;
            #1;
            if (bus8.in_valid && bus8.in_ready) begin
                macc = macc + longint'(bus8.a) * longint'(bus8.b);
                mcnt++;
                if (mcnt == 8) begin
                    if (macc > 64'd16777215) eq.push_back({1'b1, 24'hFFFFFF});
                    else eq.push_back({1'b0, 24'(macc)});
                    macc = 0;
                    mcnt = 0;
                end
            end
            cyc();
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        for (int w = 0; w < 10; w++) cyc();
        n_vec++; if (q8.size() !== eq.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", q8.size(), eq.size()); end
        n = (q8.size() < eq.size()) ? q8.size() : eq.size();
        for (int k = 0; k < n; k++) begin
            e = q8.pop_front();
            n_vec++;
            if (e !== eq[k]) begin
                n_err++;
                $display("FAIL rand_result[%0d] got %0d/%0b want %0d/%0b", k, e[23:0], e[24], eq[k][23:0], eq[k][24]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus8.clear = 1'b0;  bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.out_ready = 1'b1;
        bus16.clear = 1'b0; bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b1;
        test_reset();
        test_full_block();
        test_saturation();
        test_back_to_back();
        test_stall();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
